fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage feeding the multicycle control FSM and decode logic. Owns the program counter and the instruction register (IR), and issues read requests to instruction memory with a req/ack handshake that tolerates variable latency. Applies PC updates (increment, register jump, PC-relative branch) commanded by the control FSM's 2-bit PC-select code during execute states.

Parameters:
ADDR_W, 16, width of PC and memory address
RESET_PC, 16'h0000, PC value loaded on reset
TIMEOUT, 15, max cycles waiting for mem_ack (used only with FETCH_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
fetch_req  in  1  one-cycle strobe from control FETCH state: start fetch at current PC
pc_sel  in  2  PC update code: 00 hold, 01 increment, 10 jump to reg_target, 11 branch by disp
cond_true  in  1  condition result for pc_sel 10/11
reg_target  in  ADDR_W  jump target from register file
mem_addr  out  ADDR_W  instruction memory address
mem_rd  out  1  read request, held until mem_ack
mem_rdata  in  16  instruction memory read data
mem_ack  in  1  read data valid this cycle
instr  out  16  instruction register
instr_valid  out  1  IR holds a completed fetch not yet superseded
busy  out  1  fetch in flight; control must stall
pc  out  ADDR_W  current PC
pc_link  out  ADDR_W  pc+1 (JAL link value), combinational
seq_err  out  1  sticky: pc_sel nonzero or fetch_req while busy
fetch_fault  out  1  sticky timeout flag (FETCH_TIMEOUT_EN only, else tied 0)

Behaviour:
- States: IDLE, WAIT. Reset -> IDLE; pc=RESET_PC, instr=16'h0000, instr_valid=0, mem_rd=0, mem_addr=RESET_PC, busy=0, seq_err=0, fetch_fault=0.
- Reset mid-fetch: immediate return to IDLE, request dropped; a late mem_ack after reset release while in IDLE is ignored.
- PC update (IDLE only, applied at clock edge):
  - 01: pc <= pc+1.
  - 10: pc <= cond_true ? reg_target : pc+1.
  - 11: pc <= cond_true ? pc + sext(instr[7:0]) : pc+1.
- Arithmetic modulo 2^ADDR_W: 16'hFFFF+1 -> 16'h0000; branch wraps both directions.
- Fetch address: pc_next, the value pc takes at this edge, so a same-cycle pc_sel update and fetch_req fetch from the updated PC.
- fetch_req in IDLE:
  - next cycle: state=WAIT, mem_rd=1, mem_addr=pc_next, busy=1, instr_valid=0.
- WAIT:
  - mem_rd and mem_addr held stable until mem_ack.
  - On mem_ack: instr <= mem_rdata, instr_valid=1, mem_rd=0, busy=0, state=IDLE, all at the next edge.
  - Minimum latency: fetch_req edge to instr_valid = 2 cycles with mem_ack asserted the first WAIT cycle.
- mem_ack in IDLE is ignored.
- In WAIT, fetch_req or pc_sel!=00 is ignored (pc unchanged) and seq_err <= 1 (sticky until reset).
- instr stays stable from ack until the next ack; instr_valid clears on the cycle after fetch_req is accepted.
- busy = (state==WAIT), registered.

Optional Feature:
FETCH_TIMEOUT_EN: defined -> 4-bit wait counter cleared on entry to WAIT and incremented each WAIT cycle without mem_ack. When it reaches TIMEOUT:
- state <= IDLE, mem_rd <= 0, instr <= 16'h0000, instr_valid <= 1, fetch_fault <= 1 (sticky until reset).
- A mem_ack arriving in the same cycle as the timeout wins: normal completion, no fault.

Undefined -> no counter, WAIT persists indefinitely, fetch_fault tied 0.

Test Plan:
- Reset release, fetch_req, mem_ack on first WAIT cycle with rdata=16'h5123 -> mem_addr=16'h0000, mem_rd high 1 cycle, instr=16'h5123, instr_valid=1 two cycles after fetch_req.
- pc=16'h0010, pc_sel=11, cond_true=1, instr[7:0]=8'hFC -> pc=16'h000C; same with cond_true=0 -> pc=16'h0011.
- pc=16'hFFFF, pc_sel=01 with fetch_req same cycle -> pc=16'h0000, mem_addr=16'h0000.
- pc_sel=10, reg_target=16'h0200, cond_true=1 -> pc=16'h0200, pc_link was 16'h(old pc+1); pc_sel=01 during WAIT -> pc unchanged, seq_err=1.
- Mem_ack delayed 5 cycles -> mem_rd and mem_addr stable all 5 cycles, busy=1 throughout; reset pulsed low mid-wait -> pc=RESET_PC, mem_rd=0, instr_valid=0.
- FETCH_TIMEOUT_EN, TIMEOUT=15, no ack -> after 15 WAIT cycles: instr=16'h0000, instr_valid=1, fetch_fault=1, busy=0; ack on cycle 15 -> normal capture, fetch_fault=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register and req/ack memory read.
// Optional FETCH_TIMEOUT_EN adds a bounded wait with a sticky fetch_fault flag.
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter int                TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [1:0]        pc_sel,
    input  logic              cond_true,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [15:0]       instr,
    output logic              instr_valid,
    output logic              busy,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_link,
    output logic              seq_err,
    output logic              fetch_fault
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc_nx, addr_nx, pc_inc, disp;
    logic              rd_nx, valid_nx, seq_nx;
    logic [15:0]       instr_nx;

`ifdef FETCH_TIMEOUT_EN
    logic [3:0] wait_cnt, cnt_nx;
    logic       fault_q, fault_nx;
`endif

    assign pc_inc  = pc + 1'b1;
    assign pc_link = pc_inc;
    assign disp    = {{(ADDR_W-8){instr[7]}}, instr[7:0]};
    assign busy    = (state == WAIT);

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        addr_nx  = mem_addr;
        rd_nx    = mem_rd;
        instr_nx = instr;
        valid_nx = instr_valid;
        seq_nx   = seq_err;
`ifdef FETCH_TIMEOUT_EN
        cnt_nx   = wait_cnt;
        fault_nx = fault_q;
`endif
        case (state)
            IDLE: begin
                case (pc_sel)
                    2'b01:   pc_nx = pc_inc;
                    2'b10:   pc_nx = cond_true ? reg_target : pc_inc;
                    2'b11:   pc_nx = cond_true ? pc + disp : pc_inc;
                    default: pc_nx = pc;
                endcase
                // Fetch address is the post-update PC so a same-cycle branch is honoured.
                if (fetch_req) begin
                    state_nx = WAIT;
                    rd_nx    = 1'b1;
                    addr_nx  = pc_nx;
                    valid_nx = 1'b0;
`ifdef FETCH_TIMEOUT_EN
                    cnt_nx   = '0;
`endif
                end
            end
            WAIT: begin
                if (fetch_req || pc_sel != 2'b00)
                    seq_nx = 1'b1;
                if (mem_ack) begin
                    state_nx = IDLE;
                    rd_nx    = 1'b0;
                    instr_nx = mem_rdata;
                    valid_nx = 1'b1;
                end
`ifdef FETCH_TIMEOUT_EN
                // wait_cnt counts earlier ack-less WAIT cycles; ack in the last cycle still wins.
                else if (wait_cnt == 4'(TIMEOUT - 1)) begin
                    state_nx = IDLE;
                    rd_nx    = 1'b0;
                    instr_nx = '0;
                    valid_nx = 1'b1;
                    fault_nx = 1'b1;
                end else begin
                    cnt_nx = wait_cnt + 4'd1;
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            mem_addr    <= RESET_PC;
            mem_rd      <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            mem_addr    <= addr_nx;
            mem_rd      <= rd_nx;
            instr       <= instr_nx;
            instr_valid <= valid_nx;
            seq_err     <= seq_nx;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            wait_cnt <= cnt_nx;
            fault_q  <= fault_nx;
        end
    end

    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule
